btb_bimodal_predictor: RTL and testbench
========================================

# btb_bimodal_predictor

Direct-mapped branch target buffer with per-entry valid bits, full tags and saturating direction counters, parametrised in word size, index width and counter width. Sits in the fetch stage: it predicts the next PC combinationally from the current PC. The execute stage trains it through a one-per-cycle update port. After reset it clears its tables with an initialisation sweep, and it keeps update and mispredict statistics for performance analysis.

## Interface
- WORD_SIZE, 16, PC/target width in bits
- IDX_BITS, 8, index width; table depth = 2**IDX_BITS entries; must satisfy 1 <= IDX_BITS < WORD_SIZE
- CNT_BITS, 2, direction counter width; must be >= 1
- STAT_BITS, 16, statistics counter width

- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- fetch_pc  in  WORD_SIZE  PC being fetched
- pred_hit  out  1  valid entry with matching tag exists for fetch_pc
- pred_taken  out  1  prediction is taken
- pred_npc  out  WORD_SIZE  predicted next PC
- upd_valid  in  1  resolved branch/instruction update strobe
- upd_pc  in  WORD_SIZE  PC of resolved instruction
- upd_taken  in  1  instruction was a taken branch/jump
- upd_target  in  WORD_SIZE  resolved target (used only when upd_taken=1)
- ready  out  1  init sweep complete; lookups and updates active
- stat_updates  out  STAT_BITS  accepted updates
- stat_mispredicts  out  STAT_BITS  accepted updates that were mispredicted

## Operation
- Entry fields: valid (1 bit), tag (WORD_SIZE-IDX_BITS bits), target (WORD_SIZE bits), counter (CNT_BITS bits).
- Field extraction: idx = pc[IDX_BITS-1:0]; tag = pc[WORD_SIZE-1:IDX_BITS].
- Lookup (combinational): pred_hit = ready & valid[idx] & (tag[idx]==fetch_tag).
  - pred_taken = pred_hit & counter[idx][CNT_BITS-1].
  - pred_npc = pred_taken ? target[idx] : fetch_pc+1, truncated to WORD_SIZE bits (0xFFFF -> 0x0000 wraps).
- FSM states: INIT, READY.
  - Any edge with reset_n=0: state<=INIT, sweep_idx<=0, both stat counters <=0.
  - Each edge in INIT with reset_n=1: clears valid and counter at sweep_idx, then sweep_idx+1. When sweep_idx==2**IDX_BITS-1, state<=READY.
  - READY is held until the next reset.
- ready = (state==READY). In INIT, upd_valid is ignored: no table write and no stat change.
- Update on an edge in READY with upd_valid=1, computed against pre-edge table contents:
  - Hit (valid & tag match):
    - upd_taken=1: counter saturating +1 (max 2**CNT_BITS-1) and target<=upd_target.
    - upd_taken=0: counter saturating -1 (min 0); target unchanged.
  - Miss, upd_taken=1: allocate/replace. valid<=1, tag<=upd tag, target<=upd_target, counter<=2**(CNT_BITS-1) (weakly taken).
  - Miss, upd_taken=0: no table change.
- Mispredict for an accepted update:
  - predicted npc (same lookup rule applied to upd_pc, pre-edge) != actual npc.
  - actual npc = upd_taken ? upd_target : upd_pc+1.
- Statistics: stat_updates +1 per accepted update; stat_mispredicts +1 per mispredicted accepted update. Both saturate at all-ones and never wrap.
- Aliasing: different PCs with the same idx evict each other. No associativity.

## Timing
- Reset values: ready=0, stat_updates=0, stat_mispredicts=0, pred_hit=0, pred_taken=0, pred_npc=fetch_pc+1.
- Lookup latency 0 (combinational from fetch_pc and table state). Update latency 1: the table change is visible to lookups after the update edge.
- Same-cycle lookup and update to the same idx: lookup returns pre-update contents (no bypass).
- ready rises after exactly 2**IDX_BITS rising edges with reset_n=1 following reset release. Default depth: 256 edges.
- Reset asserted mid-sweep: sweep restarts from idx 0 and ready stays 0.
- Reset asserted in READY: ready=0 from the next edge; table contents become invalid through the sweep.
- Update throughput: one per cycle, no stall output. Lookup never stalls.

## Test plan
- Reset/init (IDX_BITS=4): hold reset_n=0 for 2 cycles, release.
  - Required: ready=0 for 16 edges, then 1; pred_npc(0x0040)=0x0041; stats=0.
  - Re-assert reset at edge 8 of the sweep: ready reappears only 16 edges after the second release.
- Allocate and predict: update pc=0x0123, taken, target=0x0200.
  - Required next cycle: fetch 0x0123 -> pred_hit=1, pred_taken=1, pred_npc=0x0200.
  - stat_updates=1, stat_mispredicts=1 (cold miss).
- Counter hysteresis: on the entry above, apply not-taken updates.
  - First: counter 2->1, pred_taken=0, pred_npc=0x0124, mispredicts +1.
  - Second: counter 0, mispredicts unchanged.
  - Two taken updates: counter 2 and pred_taken=1.
- Tag alias: allocate 0x0123 (target 0x0200), then update 0x0223 taken (target 0x0300).
  - Required: fetch 0x0123 -> pred_hit=0, pred_npc=0x0124; fetch 0x0223 -> 0x0300.
  - A not-taken update to a missing pc leaves the table unchanged.
- Wrap and bypass: fetch_pc=0xFFFF on miss -> pred_npc=0x0000.
  - Same-cycle update+lookup of the same idx: lookup shows old value, new value next cycle.
- Stat saturation (STAT_BITS=4): 20 mispredicted updates.
  - Required: stat_updates=15 and stat_mispredicts=15, held there.

Source files
------------

// File: rtl/btb_bimodal_predictor.sv
// Direct-mapped branch target buffer with bimodal saturating direction counters.
// Combinational next-PC lookup for fetch, one-per-cycle training from execute.
module btb_bimodal_predictor #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 8,
    parameter int CNT_BITS  = 2,
    parameter int STAT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] fetch_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_npc,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    output logic                 ready,
    output logic [STAT_BITS-1:0] stat_updates,
    output logic [STAT_BITS-1:0] stat_mispredicts
);

    localparam int TAG_BITS = WORD_SIZE - IDX_BITS;
    localparam int DEPTH    = 1 << IDX_BITS;

    localparam logic [WORD_SIZE-1:0] PC_ONE   = WORD_SIZE'(1);
    localparam logic [IDX_BITS-1:0]  IDX_ONE  = IDX_BITS'(1);
    localparam logic [IDX_BITS-1:0]  IDX_LAST = '1;
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0]  CNT_WEAK = CNT_ONE << (CNT_BITS - 1);
    localparam logic [STAT_BITS-1:0] STAT_ONE = STAT_BITS'(1);
    localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic logic [CNT_BITS-1:0] cnt_inc(input logic [CNT_BITS-1:0] c);
        if (c == CNT_MAX) begin
            return c;
        end else begin
            return c + CNT_ONE;
        end
    endfunction

    function automatic logic [CNT_BITS-1:0] cnt_dec(input logic [CNT_BITS-1:0] c);
        if (c == '0) begin
            return c;
        end else begin
            return c - CNT_ONE;
        end
    endfunction

    function automatic logic [STAT_BITS-1:0] stat_inc(input logic [STAT_BITS-1:0] s);
        if (s == STAT_MAX) begin
            return s;
        end else begin
            return s + STAT_ONE;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [IDX_BITS-1:0]    sweep_idx_q, sweep_idx_d;
    logic [STAT_BITS-1:0]   stat_upd_q, stat_upd_d;
    logic [STAT_BITS-1:0]   stat_misp_q, stat_misp_d;

    logic                   valid_q  [DEPTH];
    logic [TAG_BITS-1:0]    tag_q    [DEPTH];
    logic [WORD_SIZE-1:0]   target_q [DEPTH];
    logic [CNT_BITS-1:0]    cnt_q    [DEPTH];

    logic                   wr_meta_en;
    logic                   wr_data_en;
    logic [IDX_BITS-1:0]    wr_idx;
    logic                   wr_valid;
    logic [CNT_BITS-1:0]    wr_cnt;

    logic [IDX_BITS-1:0]    f_idx;
    logic [TAG_BITS-1:0]    f_tag;
    logic [IDX_BITS-1:0]    u_idx;
    logic [TAG_BITS-1:0]    u_tag;
    logic                   u_hit;
    logic                   u_pred_taken;
    logic [WORD_SIZE-1:0]   u_pred_npc;
    logic [WORD_SIZE-1:0]   u_act_npc;
    logic                   u_misp;

    assign f_idx = fetch_pc[IDX_BITS-1:0];
    assign f_tag = fetch_pc[WORD_SIZE-1:IDX_BITS];
    assign u_idx = upd_pc[IDX_BITS-1:0];
    assign u_tag = upd_pc[WORD_SIZE-1:IDX_BITS];

    assign ready            = (state_q == ST_READY);
    assign stat_updates     = stat_upd_q;
    assign stat_mispredicts = stat_misp_q;

    // Fetch-side lookup; gated by ready so stale table contents never leak during the sweep.
    always_comb begin
        pred_hit   = ready & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
        pred_taken = pred_hit & cnt_q[f_idx][CNT_BITS-1];
        if (pred_taken) begin
            pred_npc = target_q[f_idx];
        end else begin
            pred_npc = fetch_pc + PC_ONE;
        end
    end

    // Replays the fetch prediction for the resolving PC against pre-edge table state.
    always_comb begin
        u_hit        = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
        u_pred_taken = u_hit & cnt_q[u_idx][CNT_BITS-1];
        if (u_pred_taken) begin
            u_pred_npc = target_q[u_idx];
        end else begin
            u_pred_npc = upd_pc + PC_ONE;
        end
        if (upd_taken) begin
            u_act_npc = upd_target;
        end else begin
            u_act_npc = upd_pc + PC_ONE;
        end
        u_misp = (u_pred_npc != u_act_npc);
    end

    // Next-state, statistics and table write control for the init sweep and training.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        stat_upd_d  = stat_upd_q;
        stat_misp_d = stat_misp_q;
        wr_meta_en  = 1'b0;
        wr_data_en  = 1'b0;
        wr_idx      = sweep_idx_q;
        wr_valid    = 1'b0;
        wr_cnt      = '0;
        case (state_q)
            ST_INIT: begin
                wr_meta_en  = 1'b1;
                sweep_idx_d = sweep_idx_q + IDX_ONE;
                if (sweep_idx_q == IDX_LAST) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_READY: begin
                wr_idx = u_idx;
                if (upd_valid) begin
                    stat_upd_d = stat_inc(stat_upd_q);
                    if (u_misp) begin
                        stat_misp_d = stat_inc(stat_misp_q);
                    end else begin
                        stat_misp_d = stat_misp_q;
                    end
                    if (u_hit) begin
                        wr_meta_en = 1'b1;
                        wr_valid   = 1'b1;
                        if (upd_taken) begin
                            wr_cnt     = cnt_inc(cnt_q[u_idx]);
                            wr_data_en = 1'b1;
                        end else begin
                            wr_cnt     = cnt_dec(cnt_q[u_idx]);
                            wr_data_en = 1'b0;
                        end
                    end else if (upd_taken) begin
                        // Taken miss allocates (or evicts an alias) as weakly taken.
                        wr_meta_en = 1'b1;
                        wr_data_en = 1'b1;
                        wr_valid   = 1'b1;
                        wr_cnt     = CNT_WEAK;
                    end else begin
                        wr_meta_en = 1'b0;
                        wr_data_en = 1'b0;
                    end
                end else begin
                    wr_meta_en = 1'b0;
                    wr_data_en = 1'b0;
                end
            end
            default: begin
                state_d     = ST_INIT;
                sweep_idx_d = '0;
            end
        endcase
    end

    // Control and statistics registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            sweep_idx_q <= '0;
            stat_upd_q  <= '0;
            stat_misp_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            stat_upd_q  <= stat_upd_d;
            stat_misp_q <= stat_misp_d;
        end
    end

    // Table storage; cleared by the sweep rather than by reset so it can map to RAM.
    always_ff @(posedge clk) begin
        if (reset_n && wr_meta_en) begin
            valid_q[wr_idx] <= wr_valid;
            cnt_q[wr_idx]   <= wr_cnt;
        end
        if (reset_n && wr_data_en) begin
            tag_q[wr_idx]    <= u_tag;
            target_q[wr_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_btb_bimodal_predictor.sv
// Directed bench for btb_bimodal_predictor (16 entries, 4-bit stats) with an
// expectation queue popped at each sample point.
module tb_btb_bimodal_predictor;

    logic        clk;
    logic        reset_n;
    logic [15:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [15:0] pred_npc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        ready;
    logic [3:0]  stat_updates;
    logic [3:0]  stat_mispredicts;

    int errors = 0;
    int checks = 0;

    string       name_q[$];
    logic [31:0] exp_q[$];

    btb_bimodal_predictor #(
        .WORD_SIZE(16),
        .IDX_BITS (4),
        .CNT_BITS (2),
        .STAT_BITS(4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fetch_pc        (fetch_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_npc        (pred_npc),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .ready           (ready),
        .stat_updates    (stat_updates),
        .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string n, input logic [31:0] v);
        name_q.push_back(n);
        exp_q.push_back(v);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        string       n;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
        end else begin
            n = name_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", n, obs, e);
            end
        end
    endtask

    task automatic chk_lookup(input string n, input logic [15:0] pc,
                              input logic h, input logic t, input logic [15:0] npc);
        fetch_pc = pc;
        push({n, ".hit"}, {31'd0, h});
        push({n, ".taken"}, {31'd0, t});
        push({n, ".npc"}, {16'd0, npc});
        #1;
        pop_cmp({31'd0, pred_hit});
        pop_cmp({31'd0, pred_taken});
        pop_cmp({16'd0, pred_npc});
    endtask

    task automatic chk_stats(input string n, input logic [3:0] u, input logic [3:0] m);
        push({n, ".updates"}, {28'd0, u});
        push({n, ".mispredicts"}, {28'd0, m});
        #1;
        pop_cmp({28'd0, stat_updates});
        pop_cmp({28'd0, stat_mispredicts});
    endtask

    task automatic chk_ready(input string n, input logic r);
        push(n, {31'd0, r});
        pop_cmp({31'd0, ready});
    endtask

    task automatic upd(input logic [15:0] pc, input logic t, input logic [15:0] tgt);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = t;
        upd_target = tgt;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic hold_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk_ready("rst.ready", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic sweep_check(input string n);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            chk_ready($sformatf("%s.ready_e%0d", n, k), (k == 16));
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        fetch_pc   = 16'h0040;
        upd_valid  = 1'b0;
        upd_pc     = 16'h0000;
        upd_taken  = 1'b0;
        upd_target = 16'h0000;

        // Reset values
        @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk_ready("reset.ready", 1'b0);
        chk_stats("reset", 4'd0, 4'd0);
        chk_lookup("reset.look40", 16'h0040, 1'b0, 1'b0, 16'h0041);

        // Sweep interrupted at edge 8, then full sweep
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk_ready($sformatf("sweep1.ready_e%0d", k), 1'b0);
        end
        hold_reset(1);
        sweep_check("sweep2");
        chk_stats("init", 4'd0, 4'd0);
        chk_lookup("init.look40", 16'h0040, 1'b0, 1'b0, 16'h0041);

        // Allocate and predict
        upd(16'h0123, 1'b1, 16'h0200);
        chk_lookup("alloc", 16'h0123, 1'b1, 1'b1, 16'h0200);
        chk_stats("alloc", 4'd1, 4'd1);

        // Counter hysteresis
        upd(16'h0123, 1'b0, 16'h0000);
        chk_lookup("nt1", 16'h0123, 1'b1, 1'b0, 16'h0124);
        chk_stats("nt1", 4'd2, 4'd2);
        upd(16'h0123, 1'b0, 16'h0000);
        chk_lookup("nt2", 16'h0123, 1'b1, 1'b0, 16'h0124);
        chk_stats("nt2", 4'd3, 4'd2);
        upd(16'h0123, 1'b1, 16'h0200);
        chk_lookup("t1", 16'h0123, 1'b1, 1'b0, 16'h0124);
        chk_stats("t1", 4'd4, 4'd3);
        upd(16'h0123, 1'b1, 16'h0200);
        chk_lookup("t2", 16'h0123, 1'b1, 1'b1, 16'h0200);
        chk_stats("t2", 4'd5, 4'd4);
        upd(16'h0123, 1'b1, 16'h0200);
        upd(16'h0123, 1'b1, 16'h0200);
        chk_stats("t_sat", 4'd7, 4'd4);
        upd(16'h0123, 1'b0, 16'h0000);
        chk_lookup("sat_nt", 16'h0123, 1'b1, 1'b1, 16'h0200);
        chk_stats("sat_nt", 4'd8, 4'd5);
        upd(16'h0123, 1'b1, 16'h0250);
        chk_lookup("retarget", 16'h0123, 1'b1, 1'b1, 16'h0250);
        chk_stats("retarget", 4'd9, 4'd6);

        // Tag alias eviction and not-taken misses
        upd(16'h0223, 1'b1, 16'h0300);
        chk_lookup("alias.old", 16'h0123, 1'b0, 1'b0, 16'h0124);
        chk_lookup("alias.new", 16'h0223, 1'b1, 1'b1, 16'h0300);
        chk_stats("alias", 4'd10, 4'd7);
        upd(16'h0555, 1'b0, 16'h0000);
        chk_lookup("ntmiss", 16'h0555, 1'b0, 1'b0, 16'h0556);
        upd(16'h0123, 1'b0, 16'h0000);
        chk_lookup("ntalias", 16'h0223, 1'b1, 1'b1, 16'h0300);
        chk_stats("ntmiss", 4'd12, 4'd7);

        // Wrap and same-cycle update/lookup
        chk_lookup("wrap", 16'hFFFF, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 16'h0223;
        upd_taken  = 1'b0;
        upd_target = 16'h0000;
        chk_lookup("bypass.pre", 16'h0223, 1'b1, 1'b1, 16'h0300);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        chk_lookup("bypass.post", 16'h0223, 1'b1, 1'b0, 16'h0224);
        chk_stats("bypass", 4'd13, 4'd8);

        // Reset from READY with updates offered during the sweep
        hold_reset(2);
        upd_valid  = 1'b1;
        upd_pc     = 16'h0010;
        upd_taken  = 1'b1;
        upd_target = 16'h0999;
        sweep_check("sweep3");
        @(negedge clk);
        upd_valid = 1'b0;
        chk_stats("sweep3", 4'd0, 4'd0);
        chk_lookup("sweep3.inval", 16'h0223, 1'b0, 1'b0, 16'h0224);
        chk_lookup("sweep3.noupd", 16'h0010, 1'b0, 1'b0, 16'h0011);

        // Statistic saturation
        for (int i = 1; i <= 20; i++) begin
            upd(16'h0010, 1'b1, 16'h1000 + 16'(i));
            chk_stats($sformatf("sat%0d", i), (i > 15) ? 4'd15 : 4'(i), (i > 15) ? 4'd15 : 4'(i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
